ctrl_sweep_sequencer: RTL

Exhaustive-sweep sequencer for the 7-input / 26-output `ctrl` combinational benchmark. It drives every input pattern in turn into an exact and an approximate copy of the circuit, waits a settle interval, and samples both outputs. It accumulates error metrics (erroneous-pattern count, total Hamming distance, worst-case Hamming distance) in hardware. It sits beside the two DUT instances in the approximate-synthesis evaluation harness and replaces the per-pattern `$display` dump.

---
 rtl/ctrl_sweep_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/ctrl_sweep_sequencer.sv
// ctrl_sweep_sequencer: exhaustive input sweep of exact/approx ctrl DUTs with error metrics.
// Define CTRL_SWEEP_MISR_EN to compress po_exact into a MISR signature on sig.
module ctrl_sweep_sequencer #(
  parameter int PI_W = 7,
  parameter int PO_W = 26,
  parameter int SETTLE = 1,
  parameter logic [PO_W-1:0] MISR_POLY = 26'h0000047,
  localparam int HD_W = $clog2(PO_W + 1),
  localparam int EB_W = PI_W + HD_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [PO_W-1:0] po_exact,
  input  logic [PO_W-1:0] po_approx,
  output logic [PI_W-1:0] pi_out,
  output logic            busy,
  output logic            done,
  output logic [PI_W:0]   err_patterns,
  output logic [EB_W-1:0] err_bits,
  output logic [HD_W-1:0] max_hd,
  output logic [PO_W-1:0] sig
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [HD_W-1:0] hd;
  logic [PO_W-1:0] diff;
  assign diff = po_exact ^ po_approx;
  always_comb begin
    hd = '0;
    for (int i = 0; i < PO_W; i++) hd = hd + HD_W'(diff[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      pi_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_patterns <= '0;
      err_bits <= '0;
      max_hd <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          pi_out <= '0;
          err_patterns <= '0;
          err_bits <= '0;
          max_hd <= '0;
          cnt <= CW'(SETTLE);
          busy <= 1'b1;
          state <= SETTLE == 0 ? S_SAMPLE : S_SETTLE;
        end
        S_SETTLE: if (abort) begin
          state <= S_IDLE;
          pi_out <= '0;
          busy <= 1'b0;
        end else begin
          cnt <= cnt - CW'(1);
          state <= cnt == CW'(1) ? S_SAMPLE : S_SETTLE;
        end
        S_SAMPLE: if (abort) begin
          state <= S_IDLE;
          pi_out <= '0;
          busy <= 1'b0;
        end else begin
          err_patterns <= err_patterns + (PI_W+1)'(hd != '0);
          err_bits <= err_bits + EB_W'(hd);
          max_hd <= hd > max_hd ? hd : max_hd;
          if (&pi_out) begin
            state <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            pi_out <= pi_out + PI_W'(1);
            cnt <= CW'(SETTLE);
            state <= SETTLE == 0 ? S_SAMPLE : S_SETTLE;
          end
        end
        S_DONE: begin
          pi_out <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef CTRL_SWEEP_MISR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig <= '0;
    else if (state == S_IDLE && start) sig <= '0;
    else if (state == S_SAMPLE && !abort)
      sig <= {sig[PO_W-2:0], 1'b0} ^ (sig[PO_W-1] ? MISR_POLY : '0) ^ po_exact;
  end
`else
  // MISR_POLY only matters when the signature is built; referencing it keeps the port list uniform.
  assign sig = MISR_POLY & {PO_W{1'b0}};
`endif
endmodule
